// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the two-port data-memory arbiter.
// Imported by the top and by anything that needs the FSM encoding.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

    localparam int unsigned DefaultDepth = 200;
    localparam int unsigned DefaultDw    = 32;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: a lone requester always wins,
// and on contention the port that was not granted last time wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       valid,
    output logic       gnt_id
);

    always_comb begin
        valid  = |req;
        gnt_id = (req == 2'b11) ? ~last_gnt : req[1];
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port data memory between
// two masters; IDLE -> ACCESS -> RESP, with a registered one-cycle ack.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = DefaultDepth,
    parameter int unsigned DW    = DefaultDw
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          req0,
    input  logic          we0,
    input  logic [DW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    output logic          err0,

    input  logic          req1,
    input  logic          we1,
    input  logic [DW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic          err1,

    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_write,
    output logic          mem_read,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy
);

    state_e        state_q, state_d;
    logic          last_gnt_q, last_gnt_d;
    logic          id_q, id_d;
    logic          we_q, we_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          err0_q, err0_d;
    logic          err1_q, err1_d;

    logic          pick_valid;
    logic          pick_id;
    logic          in_range;
    logic [DW-1:0] access_rdata;

    rr_pick2 u_pick (
        .req      ({req1, req0}),
        .last_gnt (last_gnt_q),
        .valid    (pick_valid),
        .gnt_id   (pick_id)
    );

    always_comb begin
        in_range     = (addr_q < DW'(DEPTH));
        access_rdata = (!we_q && in_range) ? mem_rdata : '0;
    end

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        id_d       = id_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        err0_d     = err0_q;
        err1_d     = err1_q;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d = StAccess;
                    id_d    = pick_id;
                    we_d    = pick_id ? we1    : we0;
                    addr_d  = pick_id ? addr1  : addr0;
                    wdata_d = pick_id ? wdata1 : wdata0;
                end
            end
            StAccess: begin
                // Response registers load here so they are valid during RESP.
                state_d = StResp;
                if (id_q) begin
                    ack1_d   = 1'b1;
                    rdata1_d = access_rdata;
                    err1_d   = ~in_range;
                end else begin
                    ack0_d   = 1'b1;
                    rdata0_d = access_rdata;
                    err0_d   = ~in_range;
                end
            end
            StResp: begin
                state_d    = StIdle;
                last_gnt_d = id_q;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            last_gnt_q <= 1'b1;
            id_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            id_q       <= id_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            err0_q     <= err0_d;
            err1_q     <= err1_d;
        end
    end

    // Memory strobes decode straight from the state so they vanish with async reset.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        if (state_q == StAccess) begin
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            mem_write = we_q & in_range;
            mem_read  = ~we_q & in_range;
        end
    end

    always_comb begin
        ack0   = ack0_q;
        ack1   = ack1_q;
        rdata0 = rdata0_q;
        rdata1 = rdata1_q;
        err0   = err0_q;
        err1   = err1_q;
        busy   = (state_q != StIdle);
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised bench for dmem_arbiter against a transaction-level model of
// grant order, latency, memory contents and per-port response registers.
module tb_dmem_arbiter;

    localparam int unsigned DEPTH = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, we0, ack0, err0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        req1, we1, ack1, err1;
    logic [31:0] addr1, wdata1, rdata1;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_write, mem_read, busy;

    logic [31:0] mem [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int          cyc;
    int          cap_edge;
    int          free_edge;
    int          last;
    int          w_id;
    logic        w_we;
    logic [31:0] w_addr, w_wdata;
    logic [31:0] exp_rdata [2];
    logic        exp_err [2];

    always #5 clk = ~clk;

    dmem_arbiter #(
        .DEPTH (DEPTH),
        .DW    (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .ack0      (ack0),
        .rdata0    (rdata0),
        .err0      (err0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .ack1      (ack1),
        .rdata1    (rdata1),
        .err1      (err1),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    assign mem_rdata = (mem_addr < DEPTH) ? mem[mem_addr[7:0]] : 32'd0;

    always @(posedge clk) begin
        if (mem_write && mem_addr < DEPTH) mem[mem_addr[7:0]] <= mem_wdata;
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        cyc       = 0;
        cap_edge  = -10;
        free_edge = 0;
        last      = 1;
        w_id      = 0;
        w_we      = 1'b0;
        w_addr    = '0;
        w_wdata   = '0;
        for (int p = 0; p < 2; p++) begin
            exp_rdata[p] = '0;
            exp_err[p]   = 1'b0;
        end
    endtask

    // Called just after each rising edge: commit the access leaving ACCESS,
    // then decide whether a new transaction is captured on this edge.
    task automatic model_edge();
        logic [1:0] r;
        bit         inr;
        cyc++;
        if (cyc == cap_edge + 1) begin
            inr = (w_addr < DEPTH);
            exp_rdata[w_id] = (!w_we && inr) ? ref_mem[w_addr[7:0]] : 32'd0;
            exp_err[w_id]   = !inr;
            if (w_we && inr) ref_mem[w_addr[7:0]] = w_wdata;
        end
        r = {req1, req0};
        if (cyc >= free_edge && r != 2'b00) begin
            if (r == 2'b11) w_id = 1 - last;
            else            w_id = r[1] ? 1 : 0;
            last      = w_id;
            w_we      = (w_id == 1) ? we1    : we0;
            w_addr    = (w_id == 1) ? addr1  : addr0;
            w_wdata   = (w_id == 1) ? wdata1 : wdata0;
            cap_edge  = cyc;
            free_edge = cyc + 3;
        end
    endtask

    task automatic check_cycle();
        bit acc, rsp, inr;
        acc = (cyc == cap_edge);
        rsp = (cyc == cap_edge + 1);
        inr = (w_addr < DEPTH);
        check("busy",      busy,      acc || rsp);
        check("mem_write", mem_write, acc && w_we && inr);
        check("mem_read",  mem_read,  acc && !w_we && inr);
        check("mem_addr",  mem_addr,  acc ? w_addr : 32'd0);
        check("mem_wdata", mem_wdata, acc ? w_wdata : 32'd0);
        check("ack0",      ack0,      rsp && w_id == 0);
        check("ack1",      ack1,      rsp && w_id == 1);
        check("rdata0",    rdata0,    exp_rdata[0]);
        check("rdata1",    rdata1,    exp_rdata[1]);
        check("err0",      err0,      exp_err[0]);
        check("err1",      err1,      exp_err[1]);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic set_port(int p, bit r, bit we, logic [31:0] a, logic [31:0] d);
        if (p == 0) begin
            req0 = r; we0 = we; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = we; addr1 = a; wdata1 = d;
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        set_port(0, 0, 0, 0, 0);
        set_port(1, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_cycle();
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return 32'd200 + 32'($urandom_range(0, 1));
            1:       return 32'hFFFF_FFFF;
            2:       return 32'd199;
            default: return 32'($urandom_range(0, 15));
        endcase
    endfunction

    // One transaction on port p; operands are scrambled during ACCESS.
    task automatic txn(int p, bit we, logic [31:0] a, logic [31:0] d);
        bit got = 1'b0;
        set_port(p, 1, we, a, d);
        for (int i = 0; i < 8 && !got; i++) begin
            step();
            if ((p == 0 && ack0) || (p == 1 && ack1)) got = 1'b1;
            else if (cyc == cap_edge && w_id == p) set_port(p, 1, ~we, a ^ 32'h3, ~d);
        end
        check("txn_ack_seen", 32'(got), 32'd1);
        set_port(p, 0, 0, 0, 0);
    endtask

    task automatic drive_port(int p);
        logic ack_p, req_p;
        ack_p = (p == 1) ? ack1 : ack0;
        req_p = (p == 1) ? req1 : req0;
        if (ack_p) begin
            if ($urandom_range(0, 1) == 1)
                set_port(p, 1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
            else
                set_port(p, 0, 0, 0, 0);
        end else if (!req_p) begin
            if ($urandom_range(0, 9) < 4)
                set_port(p, 1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
        end else if (cyc == cap_edge && w_id == p) begin
            set_port(p, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rand_addr(),
                     $urandom);
        end
    endtask

    initial begin
        int order[$];
        int ack_cyc[$];
        bit stop;

        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        model_reset();

        // Reset, then a reset that lands in the ACCESS cycle of a write
        reset_dut();
        set_port(0, 1, 1, 32'd5, 32'hAA);
        step();
        rst = 1'b1;
        #1;
        check("rst_mem_write_drop", 32'(mem_write), 32'd0);
        check("rst_busy_drop", 32'(busy), 32'd0);
        set_port(0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (3) step();
        check("rst_no_commit", mem[5], 32'd0);

        // Port 0 write then read back
        txn(0, 1, 32'd2, 32'd100);
        txn(0, 0, 32'd2, 32'd0);
        check("p0_readback", rdata0, 32'd100);
        check("p0_readback_err", 32'(err0), 32'd0);

        // Dual contention from reset, continuous: expect grants 0,1,0,1,0,1
        reset_dut();
        set_port(0, 1, 0, 32'd2, 32'd0);
        set_port(1, 1, 1, 32'd3, 32'd200);
        for (int i = 0; i < 24 && order.size() < 6; i++) begin
            step();
            if (ack0) order.push_back(0);
            if (ack1) order.push_back(1);
        end
        set_port(0, 0, 0, 0, 0);
        set_port(1, 0, 0, 0, 0);
        check("dual_count", 32'(order.size()), 32'd6);
        foreach (order[i]) check("dual_order", 32'(order[i]), 32'(i % 2));
        step();
        txn(0, 0, 32'd3, 32'd0);
        check("p0_read3", rdata0, 32'd200);

        // Out-of-range accesses on port 1
        for (int i = 0; i < 4; i++) begin
            txn(1, i[0], (i < 2) ? 32'd200 : 32'hFFFF_FFFF, 32'hDEAD_0000 + 32'(i));
            check("oor_err1", 32'(err1), 32'd1);
            check("oor_rdata1", rdata1, 32'd0);
        end

        // Lone requester held high: acks every 3 cycles
        set_port(1, 1, 0, 32'd2, 32'd0);
        for (int i = 0; i < 16 && ack_cyc.size() < 3; i++) begin
            step();
            if (ack1) ack_cyc.push_back(cyc);
        end
        set_port(1, 0, 0, 0, 0);
        check("b2b_count", 32'(ack_cyc.size()), 32'd3);
        for (int i = 1; i < ack_cyc.size(); i++)
            check("b2b_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
        step();

        // Randomised mixed traffic
        stop = 1'b0;
        for (int i = 0; i < 3000 && !stop; i++) begin
            step();
            drive_port(0);
            drive_port(1);
        end

        for (int i = 0; i < DEPTH; i++) check("mem_final", mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
